// File: rtl/game_cpu_debug_pkg.sv
// Shared defaults and helpers for the CPU debug slave system-clock bridge.
package game_cpu_debug_pkg;

  localparam int unsigned DefDrWidth    = 38;
  localparam int unsigned DefIrWidth    = 2;
  localparam int unsigned DefActionBit  = 34;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefFifoDepth  = 4;

  // Ceiling log2, returning 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_cpu_debug_toggle_sync.sv
// Synchronises a TCK-domain toggle into clk and emits a one-cycle pulse per level change.
module game_cpu_debug_toggle_sync
  import game_cpu_debug_pkg::*;
#(
  parameter int unsigned STAGES = DefSyncStages
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl_i,
  output logic pulse_o
);

  localparam int unsigned PrimeW    = clog2(STAGES + 2);
  localparam int unsigned PrimeDone = STAGES + 1;

  logic [STAGES-1:0] sync_q, sync_d;
  logic              ref_q, ref_d;
  logic [PrimeW-1:0] prime_q, prime_d;
  logic              primed;

  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], tgl_i};
    ref_d   = sync_q[STAGES-1];
    primed  = (prime_q == PrimeW'(PrimeDone));
    prime_d = primed ? prime_q : prime_q + PrimeW'(1);
    // Masked until the chain has flushed a level held through reset.
    pulse_o = primed && (sync_q[STAGES-1] != ref_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      ref_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      ref_q   <= ref_d;
      prime_q <= prime_d;
    end
  end

endmodule

// File: rtl/game_cpu_debug_cmd_bridge.sv
// System-clock side of the CPU debug slave: queues JTAG update snapshots and
// issues per-instruction action / no-action pulses with a held jdo word.
module game_cpu_debug_cmd_bridge
  import game_cpu_debug_pkg::*;
#(
  parameter int unsigned DR_WIDTH    = DefDrWidth,
  parameter int unsigned IR_WIDTH    = DefIrWidth,
  parameter int unsigned ACTION_BIT  = DefActionBit,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          udr_tgl,
  input  logic                          uir_tgl,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [DR_WIDTH-1:0]           sr,
  input  logic                          cmd_ready,
  input  logic                          overflow_clr,
  output logic                          cmd_valid,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [DR_WIDTH-1:0]           jdo,
  output logic [2**IR_WIDTH-1:0]        take_action,
  output logic [2**IR_WIDTH-1:0]        take_no_action,
  output logic                          ir_update,
  output logic [clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                          overflow
);

  localparam int unsigned Nch   = 2 ** IR_WIDTH;
  localparam int unsigned AddrW = clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic udr_edge;
  logic uir_edge;

  game_cpu_debug_toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (udr_tgl),
    .pulse_o (udr_edge)
  );

  game_cpu_debug_toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (uir_tgl),
    .pulse_o (uir_edge)
  );

  logic [IR_WIDTH-1:0] mem_ir_q [FIFO_DEPTH];
  logic [DR_WIDTH-1:0] mem_dr_q [FIFO_DEPTH];

  logic [AddrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [DR_WIDTH-1:0] jdo_q, jdo_d;
  logic [Nch-1:0]      take_act_q, take_act_d, take_noact_q, take_noact_d;
  logic                empty, full, do_push, do_pop, drop;
  logic [IR_WIDTH-1:0] head_ir;
  logic [DR_WIDTH-1:0] head_dr;

  always_comb begin
    head_ir = mem_ir_q[rptr_q];
    head_dr = mem_dr_q[rptr_q];
    empty   = (count_q == '0);
    full    = (count_q == CntW'(FIFO_DEPTH));
    do_pop  = !empty && cmd_ready;
    // A push into a full FIFO only lands if a pop frees the head slot this cycle.
    do_push = udr_edge && (!full || do_pop);
    drop    = udr_edge && full && !do_pop;

    wptr_d  = do_push ? wptr_q + AddrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AddrW'(1) : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    jdo_d        = do_pop ? head_dr : jdo_q;
    take_act_d   = '0;
    take_noact_d = '0;
    if (do_pop) begin
      if (head_dr[ACTION_BIT]) begin
        take_act_d = Nch'(1) << head_ir;
      end else begin
        take_noact_d = Nch'(1) << head_ir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      jdo_q        <= '0;
      take_act_q   <= '0;
      take_noact_q <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      jdo_q        <= jdo_d;
      take_act_q   <= take_act_d;
      take_noact_q <= take_noact_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_ir_q[wptr_q] <= ir_in;
      mem_dr_q[wptr_q] <= sr;
    end
  end

  assign cmd_valid      = !empty;
  assign cmd_ir         = empty ? '0 : head_ir;
  assign jdo            = jdo_q;
  assign take_action    = take_act_q;
  assign take_no_action = take_noact_q;
  assign ir_update      = uir_edge;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_game_cpu_debug_cmd_bridge.sv
// Self-checking bench for game_cpu_debug_cmd_bridge against a queue-based reference model.
module tb_game_cpu_debug_cmd_bridge;

  localparam int unsigned DrW   = 38;
  localparam int unsigned IrW   = 2;
  localparam int unsigned Act   = 34;
  localparam int unsigned Ss    = 2;
  localparam int unsigned Depth = 4;
  localparam int unsigned Nch   = 4;
  localparam int unsigned CntW  = 3;
  localparam int unsigned VecW  = 1 + IrW + CntW + 1 + Nch + Nch + 1 + DrW;

  logic clk = 1'b0;
  logic reset, udr_tgl, uir_tgl, cmd_ready, overflow_clr;
  logic [IrW-1:0] ir_in;
  logic [DrW-1:0] sr;
  logic cmd_valid, ir_update, overflow;
  logic [IrW-1:0] cmd_ir;
  logic [DrW-1:0] jdo;
  logic [Nch-1:0] take_action, take_no_action;
  logic [CntW-1:0] fifo_count;

  always #5 clk = ~clk;

  game_cpu_debug_cmd_bridge #(
    .DR_WIDTH    (DrW),
    .IR_WIDTH    (IrW),
    .ACTION_BIT  (Act),
    .SYNC_STAGES (Ss),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .udr_tgl        (udr_tgl),
    .uir_tgl        (uir_tgl),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .overflow_clr   (overflow_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_update      (ir_update),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  typedef struct packed {
    logic [IrW-1:0] ir;
    logic [DrW-1:0] dr;
  } ent_t;

  // Reference model state
  ent_t           mq[$];
  logic           m_ovf, m_irup;
  logic [DrW-1:0] m_jdo;
  logic [Nch-1:0] m_act, m_noact;
  int             udr_cd, uir_cd;

  int tests_run = 0;
  int tests_failed = 0;

  wire [VecW-1:0] obs = {cmd_valid, cmd_ir, fifo_count, overflow, take_action,
                         take_no_action, ir_update, jdo};

  function automatic logic [VecW-1:0] exp_vec();
    logic [IrW-1:0] hir;
    hir = (mq.size() > 0) ? mq[0].ir : '0;
    return {mq.size() > 0, hir, CntW'(mq.size()), m_ovf, m_act, m_noact, m_irup, m_jdo};
  endfunction

  // One clock edge; model follows the documented latency and queueing rules.
  task automatic tick();
    bit   push, pop, full, drop;
    ent_t h;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_jdo = '0; m_act = '0; m_noact = '0; m_irup = 0;
      udr_cd = 0; uir_cd = 0;
    end else begin
      push = 0;
      if (udr_cd > 0) begin
        udr_cd--;
        push = (udr_cd == 0);
      end
      if (uir_cd > 0) uir_cd--;
      full    = (mq.size() == Depth);
      pop     = (mq.size() > 0) && cmd_ready;
      drop    = push && full && !pop;
      m_act   = '0;
      m_noact = '0;
      if (pop) begin
        h     = mq.pop_front();
        m_jdo = h.dr;
        if (h.dr[Act]) m_act[h.ir] = 1'b1;
        else           m_noact[h.ir] = 1'b1;
      end
      if (push && !drop) begin
        h.ir = ir_in;
        h.dr = sr;
        mq.push_back(h);
      end
      if (drop) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      m_irup = (uir_cd == 1);
    end
    #1;
  endtask

  task automatic flip_udr(input logic [IrW-1:0] ir, input logic [DrW-1:0] d);
    ir_in   = ir;
    sr      = d;
    udr_tgl = ~udr_tgl;
    udr_cd  = Ss + 1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
    repeat (Ss + 3) tick();
  endtask

  task automatic test_reset();
    udr_tgl = 1;
    reset   = 1;
    repeat (3) tick();
    tests_run++;
    if (obs !== exp_vec() || obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", obs, exp_vec());
    end
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (fifo_count !== 0 || overflow !== 0 || cmd_valid !== 0) begin
        tests_failed++;
        $display("FAIL reset_held_toggle cyc%0d: count=%0d ovf=%b valid=%b expected 0",
                 i, fifo_count, overflow, cmd_valid);
      end
    end
  endtask

  task automatic test_single(input logic [IrW-1:0] ir, input logic [DrW-1:0] d,
                             input logic [Nch-1:0] want_act, input logic [Nch-1:0] want_noact);
    cmd_ready = 1;
    flip_udr(ir, d);
    for (int e = 1; e <= 6; e++) begin
      tick();
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("FAIL single_e%0d: got %h expected %h", e, obs, exp_vec());
      end
      if (e == 3) begin
        tests_run++;
        if (cmd_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL single_latency: cmd_valid=%b expected 1", cmd_valid);
        end
      end
      if (e == 4) begin
        tests_run++;
        if (take_action !== want_act || take_no_action !== want_noact || jdo !== d) begin
          tests_failed++;
          $display("FAIL single_pulse: act=%b noact=%b jdo=%h expected %b %b %h",
                   take_action, take_no_action, jdo, want_act, want_noact, d);
        end
      end
      if (e == 5) begin
        tests_run++;
        if (take_action !== 0 || take_no_action !== 0) begin
          tests_failed++;
          $display("FAIL single_one_cycle: act=%b noact=%b expected 0", take_action,
                   take_no_action);
        end
      end
    end
  endtask

  task automatic test_overflow_drain();
    logic [Nch-1:0] seen[$];
    cmd_ready = 0;
    for (int k = 0; k < 5; k++) begin
      flip_udr(IrW'(k), {$urandom, $urandom});
      repeat (Ss + 3) begin
        tick();
        tests_run++;
        if (obs !== exp_vec()) begin
          tests_failed++;
          $display("FAIL ovf_fill%0d: got %h expected %h", k, obs, exp_vec());
        end
      end
    end
    tests_run++;
    if (fifo_count !== 4 || overflow !== 1) begin
      tests_failed++;
      $display("FAIL ovf_full: count=%0d ovf=%b expected 4 1", fifo_count, overflow);
    end
    cmd_ready = 1;
    repeat (6) begin
      tick();
      if ((take_action | take_no_action) != 0) seen.push_back(take_action | take_no_action);
    end
    cmd_ready = 0;
    tests_run++;
    if (seen.size() != 4 || seen[0] !== 4'b0001 || seen[1] !== 4'b0010 ||
        seen[2] !== 4'b0100 || seen[3] !== 4'b1000) begin
      tests_failed++;
      $display("FAIL drain_order: got %0d pulses expected 4 in order 0..3", seen.size());
    end
    overflow_clr = 1;
    tick();
    overflow_clr = 0;
    tests_run++;
    if (overflow !== 0 || obs !== exp_vec()) begin
      tests_failed++;
      $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    cmd_ready = 0;
    for (int k = 0; k < 4; k++) begin
      flip_udr(IrW'($urandom), {$urandom, $urandom});
      repeat (Ss + 3) tick();
    end
    flip_udr(2'd3, {$urandom, $urandom});
    tick();
    tick();
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    tests_run++;
    if (fifo_count !== 4 || overflow !== 0 || obs !== exp_vec()) begin
      tests_failed++;
      $display("FAIL full_push_pop: count=%0d ovf=%b expected 4 0", fifo_count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      flip_udr(IrW'(k), {$urandom, $urandom});
      repeat (Ss + 3) tick();
    end
    tests_run++;
    if (fifo_count !== 3) begin
      tests_failed++;
      $display("FAIL mid_queued: count=%0d expected 3", fifo_count);
    end
    reset     = 1;
    cmd_ready = 1;
    tick();
    tests_run++;
    if (fifo_count !== 0 || take_action !== 0 || take_no_action !== 0 || cmd_valid !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset: count=%0d act=%b noact=%b expected 0", fifo_count,
               take_action, take_no_action);
    end
    reset = 0;
    tick();
    tests_run++;
    if (take_action !== 0 || take_no_action !== 0) begin
      tests_failed++;
      $display("FAIL mid_no_pulse: act=%b noact=%b expected 0", take_action, take_no_action);
    end
    cmd_ready = 0;
    repeat (Ss + 2) tick();
  endtask

  task automatic test_ir_update();
    int pulses = 0;
    uir_tgl = ~uir_tgl;
    uir_cd  = Ss + 1;
    repeat (6) begin
      tick();
      if (ir_update === 1'b1) pulses++;
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("FAIL ir_update_cyc: got %h expected %h", obs, exp_vec());
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL ir_update_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_random();
    int ugap = 0;
    int igap = 0;
    for (int c = 0; c < 400; c++) begin
      cmd_ready    = ($urandom_range(0, 2) != 0);
      overflow_clr = ($urandom_range(0, 15) == 0);
      if (ugap >= Ss + 2 && $urandom_range(0, 1) == 1) begin
        flip_udr(IrW'($urandom), {$urandom, $urandom});
        ugap = 0;
      end
      if (igap >= Ss + 2 && $urandom_range(0, 5) == 0) begin
        uir_tgl = ~uir_tgl;
        uir_cd  = Ss + 1;
        igap    = 0;
      end
      tick();
      ugap++;
      igap++;
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_c%0d: got %h expected %h", c, obs, exp_vec());
      end
    end
    cmd_ready    = 0;
    overflow_clr = 0;
  endtask

  initial begin
    reset = 1; udr_tgl = 0; uir_tgl = 0; ir_in = '0; sr = '0;
    cmd_ready = 0; overflow_clr = 0;
    m_ovf = 0; m_irup = 0; m_jdo = '0; m_act = '0; m_noact = '0; udr_cd = 0; uir_cd = 0;
    test_reset();
    test_single(2'd2, 38'h4_0000_0ABC, 4'b0100, 4'b0000);
    test_single(2'd1, {$urandom, $urandom} & ~(38'd1 << Act), 4'b0000, 4'b0010);
    test_overflow_drain();
    test_full_push_pop();
    test_reset_mid();
    test_ir_update();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
